id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
ID/EX pipeline stage register for the 5-stage RV32I core. It sits directly downstream of the decode control logic and captures its control outputs (alu_src, mem_write, load/store type, wb_load, wb_reg_file, invalid_inst) plus the operand, immediate and PC fields into EX. It also owns load-use hazard detection, so it inserts bubbles and drives the IF/ID stall. It applies EX flush and downstream back-pressure, and suppresses side effects of illegal instructions.

Parameters:
XLEN, 32, datapath width of pc/rs data/imm
REG_AW, 5, register address width

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  ID instruction PC
id_rs1_data  in  XLEN  rs1 operand
id_rs2_data  in  XLEN  rs2 operand
id_imm  in  XLEN  decoded immediate
id_rs1_addr  in  REG_AW  rs1 index
id_rs2_addr  in  REG_AW  rs2 index
id_rd_addr  in  REG_AW  rd index
id_rs1_used  in  1  instruction reads rs1
id_rs2_used  in  1  instruction reads rs2
id_func3  in  3  func3 passthrough
id_alu_src  in  1  decode: immediate operand select
id_mem_write  in  1  decode: store
id_mem_load_type  in  3  decode: load type (111 = default)
id_mem_store_type  in  2  decode: store type (11 = disabled)
id_wb_load  in  1  decode: load writes back from memory
id_wb_reg_file  in  1  decode: register write enable
id_invalid_inst  in  1  decode: illegal opcode
ex_flush  in  1  branch/jump redirect from EX, kill ID->EX transfer
ex_stall  in  1  downstream back-pressure, hold EX contents
ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_func3, ex_alu_src, ex_mem_write, ex_mem_load_type, ex_mem_store_type, ex_wb_load, ex_wb_reg_file  out  matching widths  registered EX copies
ex_illegal  out  1  EX holds an illegal instruction
id_stall  out  1  combinational: hold PC and IF/ID this cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. On reset, every ex_* output is a bubble.
- Bubble definition: ex_valid=0, all data/address fields 0, ex_alu_src/mem_write/wb_load/wb_reg_file/illegal=0, ex_mem_load_type=3'b111, ex_mem_store_type=2'b11.
- Load-use hazard (combinational): hazard = ex_valid & ex_wb_load & (ex_rd_addr!=0) & id_valid & ((id_rs1_used & id_rs1_addr==ex_rd_addr) | (id_rs2_used & id_rs2_addr==ex_rd_addr)).
- Stall output: id_stall = ~ex_flush & (ex_stall | hazard).
- Per-edge priority, highest first:
  1. ex_flush: load a bubble; ex_stall is ignored.
  2. ex_stall: hold all ex_* unchanged.
  3. hazard: load a bubble. ID is held by id_stall, so the instruction re-presents next cycle and proceeds once the load has left EX.
  4. ~id_valid: load a bubble.
  5. Otherwise capture all id_* fields, ex_valid=1.
- Illegal capture: when capturing with id_invalid_inst=1, set ex_valid=1 and ex_illegal=1, and capture pc/rd. Force ex_mem_write=0, ex_wb_reg_file=0, ex_wb_load=0, store type 11, load type 111. No architectural side effect.
- Latency: one cycle ID->EX. No combinational path from id_* to ex_*; the only combinational output is id_stall.
- rd=x0 load never triggers a hazard.
- rst asserted mid-stall: immediate bubble; id_stall follows the reset-state ex_wb_load=0.

Optional Feature:
Macro ID_EX_PERF_CNT_EN.
- Defined: adds outputs perf_bubble_cnt[15:0] and perf_flush_cnt[15:0]. Each counts edges where priority 3 (hazard) or priority 1 (flush) was taken, respectively. Counters saturate at 16'hFFFF and reset to 0 on rst.
- Undefined: no ports and no counter logic; behaviour otherwise identical.

Test Plan:
- Reset: assert rst mid-capture -> all ex_* equal the bubble values immediately (async), ex_mem_store_type=11, ex_mem_load_type=111.
- Plain capture: id_valid=1 add-immediate, pc=0x100, imm=5, rd=3, alu_src=1, wb_reg_file=1 -> next edge ex_valid=1, ex_pc=0x100, ex_imm=5, ex_rd_addr=3, id_stall=0.
- Load-use: EX holds a load with rd=5; ID has rs1=5, rs1_used=1 -> id_stall=1, next edge bubble in EX. Following cycle the same ID instruction is captured, with id_stall=0. Repeat with rd=0 -> no stall.
- Flush beats stall: ex_flush=1 and ex_stall=1 with a valid ID -> id_stall=0, next edge bubble. ex_stall alone for 3 cycles -> ex_* unchanged, id_stall=1 throughout.
- Illegal: id_invalid_inst=1, id_mem_write=1, id_wb_reg_file=1 -> ex_valid=1, ex_illegal=1, ex_mem_write=0, ex_wb_reg_file=0, ex_mem_store_type=11.
- Perf (ID_EX_PERF_CNT_EN defined): 3 load-use bubbles and 2 flushes -> perf_bubble_cnt=3, perf_flush_cnt=2. Preload the counter near 0xFFFF and trigger more events -> holds at 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline stage register for the 5-stage RV32I core.
//
// Captures the decode control outputs together with the PC, operand and
// immediate fields into EX. It also detects load-use hazards, inserting a
// bubble and holding IF/ID through id_stall. It applies the EX flush and
// downstream back-pressure, and neutralises the side effects of illegal
// instructions.
//
// Ports:
//   clk, rst            core clock (rising edge), async active-high reset
//   id_*                decoded instruction fields presented by ID
//   ex_flush            EX redirect: kill the ID->EX transfer
//   ex_stall            downstream back-pressure: hold EX contents
//   ex_*                registered EX copies of the id_* fields
//   ex_illegal          EX holds an illegal instruction
//   id_stall            combinational: hold PC and IF/ID this cycle
//   perf_bubble_cnt     (ID_EX_PERF_CNT_EN) saturating count of hazard bubbles
//   perf_flush_cnt      (ID_EX_PERF_CNT_EN) saturating count of flushes
//
// Optional feature macro: ID_EX_PERF_CNT_EN
module id_ex_stage_reg #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [2:0]        id_func3,
    input  logic              id_alu_src,
    input  logic              id_mem_write,
    input  logic [2:0]        id_mem_load_type,
    input  logic [1:0]        id_mem_store_type,
    input  logic              id_wb_load,
    input  logic              id_wb_reg_file,
    input  logic              id_invalid_inst,
    input  logic              ex_flush,
    input  logic              ex_stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rs1_addr,
    output logic [REG_AW-1:0] ex_rs2_addr,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic [2:0]        ex_func3,
    output logic              ex_alu_src,
    output logic              ex_mem_write,
    output logic [2:0]        ex_mem_load_type,
    output logic [1:0]        ex_mem_store_type,
    output logic              ex_wb_load,
    output logic              ex_wb_reg_file,
    output logic              ex_illegal,
    output logic              id_stall
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [15:0]       perf_bubble_cnt,
    output logic [15:0]       perf_flush_cnt
`endif
);

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1_addr;
        logic [REG_AW-1:0] rs2_addr;
        logic [REG_AW-1:0] rd_addr;
        logic [2:0]        func3;
        logic              alu_src;
        logic              mem_write;
        logic [2:0]        mem_load_type;
        logic [1:0]        mem_store_type;
        logic              wb_load;
        logic              wb_reg_file;
        logic              illegal;
    } ex_t;

    // Bubble: everything zero except the "disabled" memory type encodings.
    function automatic ex_t bubble();
        ex_t b;
        b                = '0;
        b.mem_load_type  = 3'b111;
        b.mem_store_type = 2'b11;
        return b;
    endfunction

    ex_t  ex_q;
    ex_t  id_cap;
    logic hazard;

    always_comb begin
        hazard = ex_q.valid & ex_q.wb_load & (ex_q.rd_addr != '0) & id_valid &
                 ((id_rs1_used & (id_rs1_addr == ex_q.rd_addr)) |
                  (id_rs2_used & (id_rs2_addr == ex_q.rd_addr)));
    end

    assign id_stall = ~ex_flush & (ex_stall | hazard);

    always_comb begin
        id_cap.valid          = 1'b1;
        id_cap.pc             = id_pc;
        id_cap.rs1_data       = id_rs1_data;
        id_cap.rs2_data       = id_rs2_data;
        id_cap.imm            = id_imm;
        id_cap.rs1_addr       = id_rs1_addr;
        id_cap.rs2_addr       = id_rs2_addr;
        id_cap.rd_addr        = id_rd_addr;
        id_cap.func3          = id_func3;
        id_cap.alu_src        = id_alu_src;
        id_cap.mem_write      = id_mem_write;
        id_cap.mem_load_type  = id_mem_load_type;
        id_cap.mem_store_type = id_mem_store_type;
        id_cap.wb_load        = id_wb_load;
        id_cap.wb_reg_file    = id_wb_reg_file;
        id_cap.illegal        = 1'b0;
        // Illegal instructions travel down the pipe for trap reporting but
        // must not write memory or the register file.
        if (id_invalid_inst) begin
            id_cap.illegal        = 1'b1;
            id_cap.mem_write      = 1'b0;
            id_cap.wb_reg_file    = 1'b0;
            id_cap.wb_load        = 1'b0;
            id_cap.mem_load_type  = 3'b111;
            id_cap.mem_store_type = 2'b11;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= bubble();
        end else if (ex_flush) begin
            ex_q <= bubble();
        end else if (ex_stall) begin
            ex_q <= ex_q;
        end else if (hazard || !id_valid) begin
            ex_q <= bubble();
        end else begin
            ex_q <= id_cap;
        end
    end

    assign ex_valid          = ex_q.valid;
    assign ex_pc             = ex_q.pc;
    assign ex_rs1_data       = ex_q.rs1_data;
    assign ex_rs2_data       = ex_q.rs2_data;
    assign ex_imm            = ex_q.imm;
    assign ex_rs1_addr       = ex_q.rs1_addr;
    assign ex_rs2_addr       = ex_q.rs2_addr;
    assign ex_rd_addr        = ex_q.rd_addr;
    assign ex_func3          = ex_q.func3;
    assign ex_alu_src        = ex_q.alu_src;
    assign ex_mem_write      = ex_q.mem_write;
    assign ex_mem_load_type  = ex_q.mem_load_type;
    assign ex_mem_store_type = ex_q.mem_store_type;
    assign ex_wb_load        = ex_q.wb_load;
    assign ex_wb_reg_file    = ex_q.wb_reg_file;
    assign ex_illegal        = ex_q.illegal;

`ifdef ID_EX_PERF_CNT_EN
    // A hazard bubble only counts when it actually wins the edge, i.e. no
    // flush or back-pressure overrides it.
    logic bubble_taken;
    assign bubble_taken = ~ex_flush & ~ex_stall & hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_bubble_cnt <= '0;
            perf_flush_cnt  <= '0;
        end else begin
            if (bubble_taken && (perf_bubble_cnt != 16'hFFFF))
                perf_bubble_cnt <= perf_bubble_cnt + 16'd1;
            if (ex_flush && (perf_flush_cnt != 16'hFFFF))
                perf_flush_cnt <= perf_flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_rs1_used, id_rs2_used;
    logic [2:0]  id_func3;
    logic        id_alu_src, id_mem_write;
    logic [2:0]  id_mem_load_type;
    logic [1:0]  id_mem_store_type;
    logic        id_wb_load, id_wb_reg_file, id_invalid_inst;
    logic        ex_flush, ex_stall;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic [2:0]  ex_func3;
    logic        ex_alu_src, ex_mem_write;
    logic [2:0]  ex_mem_load_type;
    logic [1:0]  ex_mem_store_type;
    logic        ex_wb_load, ex_wb_reg_file, ex_illegal, id_stall;
`ifdef ID_EX_PERF_CNT_EN
    logic [15:0] perf_bubble_cnt, perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    id_ex_stage_reg #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_func3(id_func3),
        .id_alu_src(id_alu_src), .id_mem_write(id_mem_write),
        .id_mem_load_type(id_mem_load_type), .id_mem_store_type(id_mem_store_type),
        .id_wb_load(id_wb_load), .id_wb_reg_file(id_wb_reg_file),
        .id_invalid_inst(id_invalid_inst), .ex_flush(ex_flush), .ex_stall(ex_stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1_addr(ex_rs1_addr),
        .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr), .ex_func3(ex_func3),
        .ex_alu_src(ex_alu_src), .ex_mem_write(ex_mem_write),
        .ex_mem_load_type(ex_mem_load_type), .ex_mem_store_type(ex_mem_store_type),
        .ex_wb_load(ex_wb_load), .ex_wb_reg_file(ex_wb_reg_file),
        .ex_illegal(ex_illegal), .id_stall(id_stall)
`ifdef ID_EX_PERF_CNT_EN
        , .perf_bubble_cnt(perf_bubble_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1a, rs2a, rda;
        logic        u1, u2;
        logic [2:0]  f3;
        logic        alu, mw;
        logic [2:0]  lt;
        logic [1:0]  st;
        logic        wl, wr, inv, flush, stall;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1a, rs2a, rda;
        logic [2:0]  f3;
        logic        alu, mw;
        logic [2:0]  lt;
        logic [1:0]  st;
        logic        wl, wr, ill;
    } out_t;

    typedef struct {
        in_t  i;
        logic stl;
        out_t o;
    } vec_t;

    localparam int CAP  = 0;
    localparam int BUB  = 1;
    localparam int HOLD = 2;

    vec_t tbl[$];
    out_t sb[$];
    out_t last_o;
    int   nvec = 0;
    int   nerr = 0;

    function automatic in_t mk(input logic [31:0] pc, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic wl,
                               input logic wr, input logic mw, input logic inv);
        in_t r;
        r.valid = 1'b1;  r.pc = pc;
        r.rs1d = pc ^ 32'hA5A5_0000;  r.rs2d = pc + 32'd7;  r.imm = pc >> 2;
        r.rs1a = rs1;  r.rs2a = rs2;  r.rda = rd;  r.u1 = u1;  r.u2 = u2;
        r.f3 = pc[4:2];  r.alu = pc[2];  r.mw = mw;
        r.lt = wl ? 3'b010 : 3'b111;
        r.st = mw ? 2'b10 : 2'b11;
        r.wl = wl;  r.wr = wr;  r.inv = inv;  r.flush = 1'b0;  r.stall = 1'b0;
        return r;
    endfunction

    function automatic out_t bub();
        out_t o;
        o = '0;  o.lt = 3'b111;  o.st = 2'b11;
        return o;
    endfunction

    function automatic out_t cap(input in_t v);
        out_t o;
        o.valid = 1'b1;  o.pc = v.pc;  o.rs1d = v.rs1d;  o.rs2d = v.rs2d;
        o.imm = v.imm;  o.rs1a = v.rs1a;  o.rs2a = v.rs2a;  o.rda = v.rda;
        o.f3 = v.f3;  o.alu = v.alu;  o.mw = v.mw;  o.lt = v.lt;  o.st = v.st;
        o.wl = v.wl;  o.wr = v.wr;  o.ill = 1'b0;
        if (v.inv) begin
            o.mw = 1'b0;  o.wr = 1'b0;  o.wl = 1'b0;
            o.st = 2'b11;  o.lt = 3'b111;  o.ill = 1'b1;
        end
        return o;
    endfunction

    function automatic out_t dut_out();
        out_t o;
        o.valid = ex_valid;  o.pc = ex_pc;  o.rs1d = ex_rs1_data;  o.rs2d = ex_rs2_data;
        o.imm = ex_imm;  o.rs1a = ex_rs1_addr;  o.rs2a = ex_rs2_addr;  o.rda = ex_rd_addr;
        o.f3 = ex_func3;  o.alu = ex_alu_src;  o.mw = ex_mem_write;
        o.lt = ex_mem_load_type;  o.st = ex_mem_store_type;
        o.wl = ex_wb_load;  o.wr = ex_wb_reg_file;  o.ill = ex_illegal;
        return o;
    endfunction

    task automatic add(input in_t i, input logic stl, input int kind);
        vec_t v;
        v.i = i;  v.stl = stl;
        if (kind == CAP)      v.o = cap(i);
        else if (kind == BUB) v.o = bub();
        else                  v.o = last_o;
        last_o = v.o;
        tbl.push_back(v);
    endtask

    task automatic drive(input in_t v);
        id_valid = v.valid;  id_pc = v.pc;  id_rs1_data = v.rs1d;  id_rs2_data = v.rs2d;
        id_imm = v.imm;  id_rs1_addr = v.rs1a;  id_rs2_addr = v.rs2a;  id_rd_addr = v.rda;
        id_rs1_used = v.u1;  id_rs2_used = v.u2;  id_func3 = v.f3;  id_alu_src = v.alu;
        id_mem_write = v.mw;  id_mem_load_type = v.lt;  id_mem_store_type = v.st;
        id_wb_load = v.wl;  id_wb_reg_file = v.wr;  id_invalid_inst = v.inv;
        ex_flush = v.flush;  ex_stall = v.stall;
    endtask

    task automatic chk_out(input string name, input out_t act, input out_t exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t t;
        out_t e;
        string nm;

        // ---- vector table ----
        t = mk(32'h100, 5'd3, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);
        t.imm = 32'd5;  t.alu = 1'b1;
        add(t, 1'b0, CAP);                                              // 0 plain addi
        add(mk(32'h104, 5'd5, 5'd1, 5'd2, 1, 0, 1, 1, 0, 0), 1'b0, CAP);  // 1 load rd5
        t = mk(32'h108, 5'd6, 5'd5, 5'd2, 1, 0, 0, 1, 0, 0);
        add(t, 1'b1, BUB);                                              // 2 load-use rs1
        add(t, 1'b0, CAP);                                              // 3 re-presented
        add(mk(32'h10c, 5'd0, 5'd1, 5'd2, 1, 0, 1, 1, 0, 0), 1'b0, CAP);  // 4 load rd0
        add(mk(32'h110, 5'd8, 5'd0, 5'd0, 1, 1, 0, 1, 0, 0), 1'b0, CAP);  // 5 rd0: no hazard
        add(mk(32'h114, 5'd7, 5'd1, 5'd2, 1, 0, 1, 1, 0, 0), 1'b0, CAP);  // 6 load rd7
        t = mk(32'h118, 5'd9, 5'd3, 5'd7, 1, 1, 0, 1, 1, 0);
        add(t, 1'b1, BUB);                                              // 7 load-use rs2
        add(t, 1'b0, CAP);                                              // 8
        add(mk(32'h11c, 5'd10, 5'd1, 5'd2, 1, 0, 1, 1, 0, 0), 1'b0, CAP); // 9 load rd10
        add(mk(32'h120, 5'd4, 5'd10, 5'd1, 0, 1, 0, 1, 0, 0), 1'b0, CAP); // 10 match but unused
        add(mk(32'h124, 5'd11, 5'd1, 5'd2, 1, 0, 1, 1, 0, 0), 1'b0, CAP); // 11 load rd11
        t = mk(32'h128, 5'd12, 5'd1, 5'd11, 0, 1, 0, 1, 0, 0);
        t.flush = 1'b1;  t.stall = 1'b1;
        add(t, 1'b0, BUB);                                              // 12 flush beats stall
        t.flush = 1'b0;  t.stall = 1'b0;  t.valid = 1'b0;
        add(t, 1'b0, BUB);                                              // 13 id_valid=0
        add(mk(32'h12c, 5'd12, 5'd1, 5'd2, 1, 0, 1, 1, 0, 0), 1'b0, CAP); // 14 load rd12
        t = mk(32'h130, 5'd13, 5'd12, 5'd2, 1, 0, 0, 1, 0, 0);
        t.valid = 1'b0;
        add(t, 1'b0, BUB);                                              // 15 invalid ID: no hazard
        add(mk(32'h200, 5'd9, 5'd1, 5'd2, 0, 0, 0, 1, 1, 1), 1'b0, CAP);  // 16 illegal
        t = mk(32'h300, 5'd14, 5'd9, 5'd9, 1, 1, 0, 1, 0, 0);
        t.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            t.pc = 32'h300 + 32'(k * 4);
            add(t, 1'b1, HOLD);                                         // 17..19 stall hold
        end
        t.stall = 1'b0;  t.flush = 1'b1;
        add(t, 1'b0, BUB);                                              // 20 flush
        add(mk(32'h140, 5'd13, 5'd1, 5'd2, 1, 0, 1, 1, 0, 0), 1'b0, CAP); // 21 load rd13
        t = mk(32'h144, 5'd15, 5'd13, 5'd2, 1, 0, 0, 1, 0, 0);
        t.stall = 1'b1;
        add(t, 1'b1, HOLD);                                             // 22 stall over hazard
        t.stall = 1'b0;
        add(t, 1'b1, BUB);                                              // 23 load-use
        add(t, 1'b0, CAP);                                              // 24

        // ---- reset ----
        rst = 1'b1;
        drive(mk(32'h0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0));
        id_valid = 1'b0;
        #1;
        chk_out("reset_state", dut_out(), bub());
        chk_val("reset_id_stall", 32'(id_stall), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ---- table through the scoreboard ----
        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            drive(tbl[k].i);
            #1;
            nm = $sformatf("v%0d_id_stall", k);
            chk_val(nm, 32'(id_stall), 32'(tbl[k].stl));
            sb.push_back(tbl[k].o);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                nvec++;  nerr++;
                $display("FAIL v%0d_scoreboard: got empty queue want entry", k);
            end else begin
                e = sb.pop_front();
                nm = $sformatf("v%0d_ex", k);
                chk_out(nm, dut_out(), e);
            end
        end

`ifdef ID_EX_PERF_CNT_EN
        chk_val("perf_bubble_cnt", 32'(perf_bubble_cnt), 32'd3);
        chk_val("perf_flush_cnt", 32'(perf_flush_cnt), 32'd2);
`endif

        // ---- async reset while a load-use stall is active ----
        @(negedge clk);
        drive(mk(32'h400, 5'd5, 5'd1, 5'd2, 1, 0, 1, 1, 0, 0));
        @(posedge clk);
        #1;
        chk_out("rst_seq_load", dut_out(), cap(mk(32'h400, 5'd5, 5'd1, 5'd2, 1, 0, 1, 1, 0, 0)));
        @(negedge clk);
        drive(mk(32'h404, 5'd6, 5'd5, 5'd0, 1, 0, 0, 1, 0, 0));
        #1;
        chk_val("rst_seq_stall_before", 32'(id_stall), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_out("rst_seq_async_bubble", dut_out(), bub());
        chk_val("rst_seq_stall_after", 32'(id_stall), 32'd0);
`ifdef ID_EX_PERF_CNT_EN
        chk_val("rst_seq_perf_bubble", 32'(perf_bubble_cnt), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

`ifdef ID_EX_PERF_CNT_EN
        // ---- flush counter saturation ----
        @(negedge clk);
        drive(mk(32'h500, 5'd1, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0));
        ex_flush = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        chk_val("perf_flush_sat", 32'(perf_flush_cnt), 32'hFFFF);
        chk_val("perf_bubble_idle", 32'(perf_bubble_cnt), 32'd0);
        @(negedge clk);
        ex_flush = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
